mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
//  Single-port byte-wide RAM controller; the responder end of the IF byte-fetch
//  interface (pc_memreq / if_addr_req_o / mem_inst_factor_i).
//  Arbitrates the RAM between IF byte fetches and MEM-stage load/store
//  (1/2/4 bytes). MEM has priority. IF is stalled for the whole MEM transaction.
//  Sits between pc_reg / mem stage and the synchronous RAM.
// PARAMETERS
//  ADDR_W  32  width of all byte addresses
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       reset, asynchronous, active-low
//  if_req_i     in   1       IF fetch request (pc_memreq; tied 1 upstream)
//  if_addr_i    in   ADDR_W  IF byte address (if_addr_req_o)
//  if_byte_o    out  8       fetched byte to IF (mem_inst_factor_i)
//  if_stall_o   out  1       IF must not advance; drives stall[0] request
//  mem_req_i    in   1       MEM transaction request, level
//  mem_we_i     in   1       1 = store, 0 = load
//  mem_size_i   in   2       00 byte, 01 half, 10/11 word
//  mem_signed_i in   1       sign-extend load result
//  mem_addr_i   in   ADDR_W  MEM start byte address
//  mem_wdata_i  in   32      store data, byte 0 = bits [7:0]
//  mem_rdata_o  out  32      load result, registered
//  mem_done_o   out  1       transaction complete, one-cycle pulse
//  ram_a_o      out  ADDR_W  RAM byte address
//  ram_wr_o     out  1       RAM write enable
//  ram_dout_o   out  8       RAM write data
//  ram_din_i    in   8       RAM read data; valid the cycle after address
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, cnt 0, byte buffer 0,
//   mem_rdata_o 0, mem_done_o 0.
//   Comb outputs in IDLE: ram_wr_o 0, ram_dout_o 0, if_stall_o 0.
//  N = 1/2/4 from mem_size_i; latched with addr/wdata/we/signed when request accepted.
//  States:
//   IDLE    ram_a_o=if_addr_i; if_byte_o=ram_din_i (every state).
//           Edge with mem_req_i=1 accepts -> RD or WR, cnt=0.
//   RD      ram_a_o=addr+cnt. At each edge with cnt>=1 capture ram_din_i->byte[cnt-1].
//           cnt==N-1 -> RD_LAST, else cnt++.
//   RD_LAST ram_a_o=if_addr_i. Edge: byte[N-1]=ram_din_i;
//           mem_rdata_o<=zero/sign-ext(bytes); mem_done_o<=1 -> DONE.
//   WR      ram_a_o=addr+cnt, ram_wr_o=1, ram_dout_o=wdata[8*cnt+:8].
//           cnt==N-1: mem_done_o<=1 -> DONE, else cnt++.
//   DONE    ram_a_o=if_addr_i; mem_done_o high this cycle only.
//           mem_req_i ignored -> IDLE; mem_done_o<=0.
//  if_stall_o = (state!=IDLE), combinational.
//   IF captures the byte in flight on the first stall cycle and replays.
//  Latency, counted from the accepting edge:
//   load: mem_done_o high in cycle N+1 (cycle 0 = first RD cycle);
//   store: mem_done_o high in cycle N.
//  mem_rdata_o holds value until next load completes; unchanged by stores.
//  mem_req_i sampled only in IDLE; requester holds inputs until mem_done_o,
//   drops req in the DONE cycle.
//  Address arithmetic wraps modulo 2^ADDR_W; misaligned accesses legal (byte-serial).
//  Extension: size byte -> bit7, half -> bit15 when mem_signed_i else zeros.
//  Reset mid-transaction: abort immediately; bytes already written stay written,
//   no mem_done_o.
// TESTING
//  1 idle: if_addr_i 0x100, RAM[0x100]=0x13 -> ram_a_o=0x100,
//    if_byte_o=0x13 next cycle, if_stall_o=0.
//  2 LW 0x1000, RAM=78 56 34 12 -> ram_a_o 0x1000..0x1003, mem_rdata_o=0x12345678,
//    done in cycle 5, stall 6 cycles.
//  3 LB signed 0x2003=0x80 -> mem_rdata_o=0xFFFFFF80;
//    unsigned LH at 0x2002 of 0x80FF -> 0x000080FF.
//  4 SH 0x3001 data 0xAABBCCDD -> RAM[0x3001]=DD, RAM[0x3002]=CC,
//    ram_wr_o 2 cycles, done in cycle 2.
//  5 back-to-back: req held through DONE -> second access accepted only after IDLE.
//    Wrap: SW at 0xFFFFFFFE writes 0xFFFFFFFE,0xFFFFFFFF,0x0,0x1.
//  6 rst=0 during WR cnt=1 of SW -> only byte0 written, outputs reset asynchronously,
//    no done pulse.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// MEM-stage request/response bundle for the RAM controller.
// Requester drives the command; the controller returns data and done.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req_i;
  logic              mem_we_i;
  logic [1:0]        mem_size_i;
  logic              mem_signed_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [31:0]       mem_wdata_i;
  logic [31:0]       mem_rdata_o;
  logic              mem_done_o;

  modport master (
    output mem_req_i,
    output mem_we_i,
    output mem_size_i,
    output mem_signed_i,
    output mem_addr_i,
    output mem_wdata_i,
    input  mem_rdata_o,
    input  mem_done_o
  );

  modport slave (
    input  mem_req_i,
    input  mem_we_i,
    input  mem_size_i,
    input  mem_signed_i,
    input  mem_addr_i,
    input  mem_wdata_i,
    output mem_rdata_o,
    output mem_done_o
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-wide single-port RAM controller: IF byte fetch vs MEM load/store.
// MEM wins; IF is stalled for the whole MEM transaction.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [7:0]        if_byte_o,
  output logic              if_stall_o,
  mem_ctrl_if.slave         mem,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic              ram_wr_o,
  output logic [7:0]        ram_dout_o,
  input  logic [7:0]        ram_din_i
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_LAST,
    WR,
    DONE
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [1:0]        cnt_q;
  logic [1:0]        last_q;
  logic [1:0]        last_in;
  logic [1:0]        idx;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              sgn_q;
  logic [23:0]       buf_q;
  logic [31:0]       rdata_q;
  logic              done_q;
  logic [31:0]       load_val;

  // IF request is tied high upstream; fetch address is always served.
  logic unused_req;
  assign unused_req = if_req_i;

  assign if_byte_o       = ram_din_i;
  assign if_stall_o      = (state_q != IDLE);
  assign mem.mem_rdata_o = rdata_q;
  assign mem.mem_done_o  = done_q;
  assign idx             = cnt_q - 2'd1;

  // Index of the final byte: 0, 1 or 3.
  always_comb begin
    last_in = 2'd3;
    unique case (mem.mem_size_i)
      2'b00:   last_in = 2'd0;
      2'b01:   last_in = 2'd1;
      default: last_in = 2'd3;
    endcase
  end

  // Assemble load result; final byte comes straight off the RAM.
  always_comb begin
    load_val = '0;
    unique case (last_q)
      2'd0: load_val = {{24{sgn_q & ram_din_i[7]}}, ram_din_i};
      2'd1: load_val = {{16{sgn_q & ram_din_i[7]}},
                        ram_din_i, buf_q[7:0]};
      default: load_val = {ram_din_i, buf_q};
    endcase
  end

  // Next state and RAM port steering.
  always_comb begin
    state_d    = state_q;
    ram_a_o    = if_addr_i;
    ram_wr_o   = 1'b0;
    ram_dout_o = 8'h00;
    unique case (state_q)
      IDLE: begin
        if (mem.mem_req_i)
          state_d = mem.mem_we_i ? WR : RD;
      end
      RD: begin
        ram_a_o = addr_q + ADDR_W'(cnt_q);
        if (cnt_q == last_q)
          state_d = RD_LAST;
      end
      RD_LAST: state_d = DONE;
      WR: begin
        ram_a_o    = addr_q + ADDR_W'(cnt_q);
        ram_wr_o   = 1'b1;
        ram_dout_o = wdata_q[{cnt_q, 3'b000} +: 8];
        if (cnt_q == last_q)
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, byte counter, latched command and load result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      last_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      sgn_q   <= 1'b0;
      buf_q   <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == DONE);
      unique case (state_q)
        IDLE: begin
          if (mem.mem_req_i) begin
            cnt_q   <= 2'd0;
            last_q  <= last_in;
            addr_q  <= mem.mem_addr_i;
            wdata_q <= mem.mem_wdata_i;
            sgn_q   <= mem.mem_signed_i;
          end
        end
        RD: begin
          if (cnt_q != 2'd0)
            buf_q[{idx, 3'b000} +: 8] <= ram_din_i;
          if (cnt_q != last_q)
            cnt_q <= cnt_q + 2'd1;
        end
        RD_LAST: rdata_q <= load_val;
        WR: begin
          if (cnt_q != last_q)
            cnt_q <= cnt_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed cases plus random loads/stores
// checked against a byte-array model of memory.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b1;
  logic [31:0] if_addr = 32'h100;
  logic [7:0]  if_byte;
  logic        if_stall;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din = 8'h00;

  mem_ctrl_if #(.ADDR_W(32)) mif ();

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req_i   (if_req),
    .if_addr_i  (if_addr),
    .if_byte_o  (if_byte),
    .if_stall_o (if_stall),
    .mem        (mif),
    .ram_a_o    (ram_a),
    .ram_wr_o   (ram_wr),
    .ram_dout_o (ram_dout),
    .ram_din_i  (ram_din)
  );

  always #5 clk = ~clk;

  logic [7:0]  ram    [65536];
  logic [7:0]  shadow [65536];
  int          n_chk = 0;
  int          n_fail = 0;
  int          done_seen = 0;
  int          wr_cnt;
  logic [31:0] last_load = 32'h0;
  logic [31:0] seq_a [8];

  // Synchronous RAM: read data appears the cycle after the address.
  always @(posedge clk) begin
    ram_din <= ram[ram_a[15:0]];
    if (ram_wr) ram[ram_a[15:0]] = ram_dout;
  end

  always @(posedge clk)
    if (mif.mem_done_o) done_seen++;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    ram[a[15:0]]    = b;
    shadow[a[15:0]] = b;
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] a,
                                             input int n, input bit sg);
    logic [31:0] v;
    logic [31:0] t;
    v = 32'h0;
    for (int i = 0; i < n; i++) begin
      t = a + 32'(i);
      v = v | (32'(shadow[t[15:0]]) << (8 * i));
    end
    if (sg && n == 1 && v[7])  v = v | 32'hFFFFFF00;
    if (sg && n == 2 && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  task automatic do_op(input bit we, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       input bit hold);
    int n;
    int k;
    int stl;
    logic [31:0] t;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    @(negedge clk);
    chk("idle_stall", {31'b0, if_stall}, 32'h0);
    chk("done_clr", {31'b0, mif.mem_done_o}, 32'h0);
    mif.mem_req_i    = 1'b1;
    mif.mem_we_i     = we;
    mif.mem_size_i   = sz;
    mif.mem_signed_i = sg;
    mif.mem_addr_i   = a;
    mif.mem_wdata_i  = wd;
    if (we) begin
      for (int i = 0; i < n; i++) begin
        t = a + 32'(i);
        shadow[t[15:0]] = wd[8*i +: 8];
      end
    end else begin
      last_load = model_load(a, n, sg);
    end
    wr_cnt = 0;
    stl = 0;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k < 8) seq_a[k] = ram_a;
      if (ram_wr) wr_cnt++;
      if (if_stall) stl++;
      if (mif.mem_done_o) break;
    end
    chk("latency", 32'(k), we ? 32'(n) : 32'(n + 1));
    chk("stall_cycles", 32'(stl), we ? 32'(n + 1) : 32'(n + 2));
    chk("rdata", mif.mem_rdata_o, last_load);
    if (!hold) mif.mem_req_i = 1'b0;
  endtask

  initial begin
    int mism;
    logic [31:0] a;
    logic [1:0]  sz;
    for (int i = 0; i < 65536; i++) begin
      ram[i]    = 8'h00;
      shadow[i] = 8'h00;
    end
    mif.mem_req_i    = 1'b0;
    mif.mem_we_i     = 1'b0;
    mif.mem_size_i   = 2'b00;
    mif.mem_signed_i = 1'b0;
    mif.mem_addr_i   = 32'h0;
    mif.mem_wdata_i  = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_rdata", mif.mem_rdata_o, 32'h0);
    chk("rst_done", {31'b0, mif.mem_done_o}, 32'h0);
    chk("rst_stall", {31'b0, if_stall}, 32'h0);
    chk("rst_wr", {31'b0, ram_wr}, 32'h0);
    chk("rst_dout", {24'b0, ram_dout}, 32'h0);
    rst = 1'b1;

    // Idle fetch path.
    poke(32'h100, 8'h13);
    @(negedge clk);
    chk("idle_addr", ram_a, 32'h100);
    @(negedge clk);
    chk("idle_byte", {24'b0, if_byte}, 32'h13);
    chk("idle_nostall", {31'b0, if_stall}, 32'h0);

    // Word load.
    poke(32'h1000, 8'h78);
    poke(32'h1001, 8'h56);
    poke(32'h1002, 8'h34);
    poke(32'h1003, 8'h12);
    do_op(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++)
      chk("lw_addr", seq_a[i], 32'h1000 + 32'(i));
    chk("lw_last_addr", seq_a[4], 32'h100);
    chk("lw_val", mif.mem_rdata_o, 32'h12345678);

    // Sign / zero extension.
    poke(32'h2003, 8'h80);
    poke(32'h2002, 8'hFF);
    do_op(1'b0, 2'b00, 1'b1, 32'h2003, 32'h0, 1'b0);
    chk("lb_sext", mif.mem_rdata_o, 32'hFFFFFF80);
    do_op(1'b0, 2'b01, 1'b0, 32'h2002, 32'h0, 1'b0);
    chk("lhu_zext", mif.mem_rdata_o, 32'h000080FF);

    // Misaligned halfword store; load result must hold.
    do_op(1'b1, 2'b01, 1'b0, 32'h3001, 32'hAABBCCDD, 1'b0);
    chk("sh_wr_cycles", 32'(wr_cnt), 32'd2);
    chk("sh_b0", {24'b0, ram[16'h3001]}, 32'hDD);
    chk("sh_b1", {24'b0, ram[16'h3002]}, 32'hCC);
    chk("sh_b2", {24'b0, ram[16'h3003]}, 32'h00);
    chk("sh_hold_rdata", mif.mem_rdata_o, 32'h000080FF);

    // Back-to-back with req held through DONE, then wrapping store.
    do_op(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 1'b1);
    do_op(1'b1, 2'b11, 1'b0, 32'hFFFFFFFE, 32'h11223344, 1'b0);
    chk("wrap_a0", seq_a[0], 32'hFFFFFFFE);
    chk("wrap_a1", seq_a[1], 32'hFFFFFFFF);
    chk("wrap_a2", seq_a[2], 32'h00000000);
    chk("wrap_a3", seq_a[3], 32'h00000001);
    chk("wrap_b3", {24'b0, ram[16'h0001]}, 32'h11);

    // Reset in the middle of a word store.
    @(negedge clk);
    done_seen = 0;
    mif.mem_req_i   = 1'b1;
    mif.mem_we_i    = 1'b1;
    mif.mem_size_i  = 2'b10;
    mif.mem_addr_i  = 32'h4000;
    mif.mem_wdata_i = 32'h44332211;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_wr", {31'b0, ram_wr}, 32'h1);
    rst = 1'b0;
    #1;
    chk("rst_mid_stall", {31'b0, if_stall}, 32'h0);
    chk("rst_mid_wr0", {31'b0, ram_wr}, 32'h0);
    chk("rst_mid_done", {31'b0, mif.mem_done_o}, 32'h0);
    chk("rst_mid_rdata", mif.mem_rdata_o, 32'h0);
    mif.mem_req_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_b0", {24'b0, ram[16'h4000]}, 32'h11);
    chk("rst_b1", {24'b0, ram[16'h4001]}, 32'h00);
    chk("rst_no_done", 32'(done_seen), 32'h0);
    shadow[16'h4000] = 8'h11;
    last_load = 32'h0;

    // Random traffic.
    repeat (150) begin
      if ($urandom_range(0, 7) == 0)
        a = 32'hFFFFFFFC + 32'($urandom_range(0, 7));
      else
        a = 32'h5000 + 32'($urandom_range(0, 63));
      sz = 2'($urandom_range(0, 3));
      do_op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
            a, $urandom, 1'($urandom_range(0, 1)));
    end

    mism = 0;
    for (int i = 16'h5000; i < 16'h5044; i++)
      if (ram[i] !== shadow[i]) mism++;
    for (int i = 16'hFFF0; i < 65536; i++)
      if (ram[i] !== shadow[i]) mism++;
    for (int i = 0; i < 16; i++)
      if (ram[i] !== shadow[i]) mism++;
    chk("ram_contents", 32'(mism), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
